// File: rtl/div_sched_if.sv
// Signal bundle between the two issue pipes, the shared divide backend and the
// result/HI-LO write-back path of div_sched.
interface div_sched_if #(
   parameter int W = 32
);
   // Issue-pipe requests
   logic         req0;
   logic [W-1:0] a0;
   logic [W-1:0] b0;
   logic         sign0;
   logic         req1;
   logic [W-1:0] a1;
   logic [W-1:0] b1;
   logic         sign1;
   logic         cancel;

   // Shared divide backend
   logic         div_start;
   logic [W-1:0] div_a;
   logic [W-1:0] div_b;
   logic         div_sign;
   logic         div_done;
   logic [W-1:0] div_quot;
   logic [W-1:0] div_rem;

   // Pipeline control and write-back
   logic         stall_all;
   logic         res_valid;
   logic         res_pipe;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         hilo_we;

   modport slave (
      input  req0, a0, b0, sign0,
      input  req1, a1, b1, sign1,
      input  cancel,
      output div_start, div_a, div_b, div_sign,
      input  div_done, div_quot, div_rem,
      output stall_all, res_valid, res_pipe, quot, rem, hilo_we
   );

   modport master (
      output req0, a0, b0, sign0,
      output req1, a1, b1, sign1,
      output cancel,
      input  div_start, div_a, div_b, div_sign,
      output div_done, div_quot, div_rem,
      input  stall_all, res_valid, res_pipe, quot, rem, hilo_we
   );
endinterface

// File: rtl/div_sched.sv
// Arbitrates the single shared divider between the two issue pipes: pipe 0 first,
// pending pipe 1 served back-to-back, with zero-divisor bypass and flush draining.
module div_sched #(
   parameter int W           = 32,
   parameter int ZERO_BYPASS = 1
) (
   input logic        clk,
   input logic        rst,
   div_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic grant;
   logic grant_nxt;
   logic pending1;
   logic pending1_nxt;
   logic first;
   logic first_nxt;

   logic           load0;
   logic           load1;
   logic           res_ld;
   logic [2*W-1:0] res_nxt;

   // Operands captured at acceptance (_p0) and the result awaiting write-back (_p1)
   logic [W-1:0] a0_p0;
   logic [W-1:0] b0_p0;
   logic         s0_p0;
   logic [W-1:0] a1_p0;
   logic [W-1:0] b1_p0;
   logic         s1_p0;
   logic [W-1:0] quot_p1;
   logic [W-1:0] rem_p1;

   logic         running;
   logic         res_fire;
   logic [W-1:0] sel_a;
   logic [W-1:0] sel_b;
   logic         sel_s;

   function automatic logic take_bypass(input logic [W-1:0] divisor);
      return (ZERO_BYPASS != 0) && (divisor == '0);
   endfunction

   // Divide-by-zero answer: all-ones quotient, remainder is the raw dividend.
   function automatic logic [2*W-1:0] bypass_result(input logic [W-1:0] dividend);
      return {{W{1'b1}}, dividend};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= 1'b0;
         pending1 <= 1'b0;
         first    <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         pending1 <= pending1_nxt;
         first    <= first_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      pending1_nxt = pending1;
      first_nxt    = 1'b0;
      load0        = 1'b0;
      load1        = 1'b0;
      res_ld       = 1'b0;
      res_nxt      = '0;
      case (state)
         IDLE: begin
            if (!bus.cancel && bus.req0) begin
               load0        = 1'b1;
               load1        = bus.req1;
               grant_nxt    = 1'b0;
               pending1_nxt = bus.req1;
               if (take_bypass(bus.b0)) begin
                  state_nxt = DONE;
                  res_ld    = 1'b1;
                  res_nxt   = bypass_result(bus.a0);
               end else begin
                  state_nxt = BUSY;
                  first_nxt = 1'b1;
               end
            end else if (!bus.cancel && bus.req1) begin
               load1        = 1'b1;
               grant_nxt    = 1'b1;
               pending1_nxt = 1'b0;
               if (take_bypass(bus.b1)) begin
                  state_nxt = DONE;
                  res_ld    = 1'b1;
                  res_nxt   = bypass_result(bus.a1);
               end else begin
                  state_nxt = BUSY;
                  first_nxt = 1'b1;
               end
            end
         end
         BUSY: begin
            // The backend cannot be aborted, so a flush must wait out its completion.
            if (bus.div_done && bus.cancel) begin
               state_nxt    = IDLE;
               pending1_nxt = 1'b0;
            end else if (bus.div_done) begin
               state_nxt = DONE;
               res_ld    = 1'b1;
               res_nxt   = {bus.div_quot, bus.div_rem};
            end else if (bus.cancel) begin
               state_nxt    = DRAIN;
               pending1_nxt = 1'b0;
            end
         end
         DONE: begin
            if (bus.cancel) begin
               state_nxt    = IDLE;
               pending1_nxt = 1'b0;
            end else if (pending1) begin
               grant_nxt    = 1'b1;
               pending1_nxt = 1'b0;
               if (take_bypass(b1_p0)) begin
                  state_nxt = DONE;
                  res_ld    = 1'b1;
                  res_nxt   = bypass_result(a1_p0);
               end else begin
                  state_nxt = BUSY;
                  first_nxt = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (bus.div_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Enables are qualified with rst so operands change only on a real acceptance.
   always_ff @(posedge clk) begin
      if (!rst && load0) begin
         a0_p0 <= bus.a0;
         b0_p0 <= bus.b0;
         s0_p0 <= bus.sign0;
      end
      if (!rst && load1) begin
         a1_p0 <= bus.a1;
         b1_p0 <= bus.b1;
         s1_p0 <= bus.sign1;
      end
      if (!rst && res_ld) begin
         {quot_p1, rem_p1} <= res_nxt;
      end
   end

   assign running  = (state == BUSY) || (state == DRAIN);
   assign res_fire = (state == DONE) && !bus.cancel;
   assign sel_a    = grant ? a1_p0 : a0_p0;
   assign sel_b    = grant ? b1_p0 : b0_p0;
   assign sel_s    = grant ? s1_p0 : s0_p0;

   assign bus.div_start = (state == BUSY) && first;
   assign bus.div_a     = running ? sel_a : '0;
   assign bus.div_b     = running ? sel_b : '0;
   assign bus.div_sign  = running ? sel_s : 1'b0;

   assign bus.res_valid = res_fire;
   assign bus.hilo_we   = res_fire;
   assign bus.res_pipe  = res_fire & grant;
   assign bus.quot      = res_fire ? quot_p1 : '0;
   assign bus.rem       = res_fire ? rem_p1 : '0;

   assign bus.stall_all = ((state == IDLE) && (bus.req0 || bus.req1) && !bus.cancel) ||
                          running ||
                          ((state == DONE) && pending1);

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed scenarios plus randomized bundles
// scored against a spec-level divide/ordering model and a behavioural backend.
module tb_div_sched;
   localparam int W = 32;

   typedef struct packed {
      logic         pipe;
      logic         stall;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_sched_if #(.W(W)) bus ();

   div_sched #(.W(W), .ZERO_BYPASS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int   lat        = 5;
   int   be_cnt     = 0;
   int   start_cnt  = 0;
   int   exp_starts = 0;
   logic mon_en     = 1'b0;
   exp_t expq[$];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Architectural result of a divide instruction.
   function automatic logic [2*W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == '0) return {{W{1'b1}}, a};
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Backend: fixed latency lat cycles from div_start to the div_done pulse.
   initial begin
      logic [W-1:0] be_q;
      logic [W-1:0] be_r;
      bus.div_done = 1'b0;
      bus.div_quot = '0;
      bus.div_rem  = '0;
      be_q = '0;
      be_r = '0;
      forever begin
         @(negedge clk);
         bus.div_done = 1'b0;
         if (be_cnt > 0) begin
            be_cnt--;
            if (be_cnt == 0) begin
               bus.div_done = 1'b1;
               bus.div_quot = be_q;
               bus.div_rem  = be_r;
            end
         end else if (bus.div_start) begin
            start_cnt++;
            if (bus.div_b == '0) {be_q, be_r} = '0;
            else {be_q, be_r} = ref_res(bus.div_a, bus.div_b, bus.div_sign);
            be_cnt = lat;
         end
      end
   end

   // Scoreboard: every result strobe must match the next expected result in order.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && bus.res_valid) begin
            if (expq.size() == 0) begin
               chk("extra_res", 1, 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("sb_pipe", bus.res_pipe, e.pipe);
               chk("sb_quot", bus.quot, e.q);
               chk("sb_rem", bus.rem, e.r);
               chk("sb_stall", bus.stall_all, e.stall);
               chk("sb_hilo", bus.hilo_we, 1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic run_bundle(input logic r0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                             input logic s0, input logic r1, input logic [W-1:0] x1,
                             input logic [W-1:0] y1, input logic s1);
      int   n;
      exp_t e;
      bus.req0 = r0; bus.a0 = x0; bus.b0 = y0; bus.sign0 = s0;
      bus.req1 = r1; bus.a1 = x1; bus.b1 = y1; bus.sign1 = s1;
      if (r0) begin
         e.pipe = 1'b0; e.stall = r1;
         {e.q, e.r} = ref_res(x0, y0, s0);
         expq.push_back(e);
         if (y0 != '0) exp_starts++;
      end
      if (r1) begin
         e.pipe = 1'b1; e.stall = 1'b0;
         {e.q, e.r} = ref_res(x1, y1, s1);
         expq.push_back(e);
         if (y1 != '0) exp_starts++;
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.stall_all && n < 100);
      if (bus.stall_all) chk("bundle_timeout", 1, 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic rnd_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic s);
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 200)) - W'(100);
      case ($urandom_range(0, 4))
         0:       b = '0;
         1:       b = W'($urandom_range(1, 15));
         2:       b = '0 - W'($urandom_range(1, 15));
         default: b = $urandom;
      endcase
      if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) b = W'(3);
   endtask

   initial begin
      logic [W-1:0] st_a[$];
      logic         st_s[$];
      exp_t         got[$];
      exp_t         g;
      int           hilo_n;
      int           base;
      int           k;
      logic         any_start, any_res, any_stall, held;
      logic [W-1:0] ra0, rb0, ra1, rb1;
      logic         rs0, rs1;
      int           sel;

      bus.req0 = 0; bus.a0 = '0; bus.b0 = '0; bus.sign0 = 0;
      bus.req1 = 0; bus.a1 = '0; bus.b1 = '0; bus.sign1 = 0;
      bus.cancel = 0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_stall", bus.stall_all, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_start", bus.div_start, 0);
      chk("rst_div_a", bus.div_a, 0);
      chk("rst_quot", bus.quot, 0);
      rst = 1'b0;
      tick();

      // Single pipe 0 unsigned 100/7, L=5
      lat = 5;
      bus.req0 = 1; bus.a0 = 100; bus.b0 = 7; bus.sign0 = 0;
      #1;
      chk("t1_stall_t0", bus.stall_all, 1);
      tick();
      chk("t1_start", bus.div_start, 1);
      chk("t1_div_a", bus.div_a, 100);
      chk("t1_div_b", bus.div_b, 7);
      chk("t1_div_sign", bus.div_sign, 0);
      for (int i = 2; i <= 6; i++) begin
         tick();
         chk("t1_stall_mid", bus.stall_all, 1);
         chk("t1_no_res", bus.res_valid, 0);
      end
      tick();
      chk("t1_res_valid", bus.res_valid, 1);
      chk("t1_quot", bus.quot, 14);
      chk("t1_rem", bus.rem, 2);
      chk("t1_pipe", bus.res_pipe, 0);
      chk("t1_hilo", bus.hilo_we, 1);
      chk("t1_stall_end", bus.stall_all, 0);
      bus.req0 = 0;
      tick();
      chk("t1_res_after", bus.res_valid, 0);

      // Dual request: pipe 0 signed -20/3, pipe 1 unsigned 9/2
      lat = 3;
      bus.req0 = 1; bus.a0 = -32'sd20; bus.b0 = 3; bus.sign0 = 1;
      bus.req1 = 1; bus.a1 = 9; bus.b1 = 2; bus.sign1 = 0;
      held = 1'b1;
      hilo_n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.div_start) begin
            st_a.push_back(bus.div_a);
            st_s.push_back(bus.div_sign);
         end
         if (bus.hilo_we) hilo_n++;
         if (bus.res_valid) begin
            g.pipe = bus.res_pipe; g.stall = bus.stall_all; g.q = bus.quot; g.r = bus.rem;
            got.push_back(g);
         end
         if (held && !bus.stall_all) begin
            bus.req0 = 0; bus.req1 = 0; held = 1'b0;
         end
      end
      chk("t2_nstart", st_a.size(), 2);
      chk("t2_nres", got.size(), 2);
      chk("t2_nhilo", hilo_n, 2);
      if (st_a.size() == 2) begin
         chk("t2_start0_a", st_a[0], 32'hFFFF_FFEC);
         chk("t2_start0_sign", st_s[0], 1);
         chk("t2_start1_a", st_a[1], 9);
         chk("t2_start1_sign", st_s[1], 0);
      end
      if (got.size() == 2) begin
         chk("t2_r0_pipe", got[0].pipe, 0);
         chk("t2_r0_quot", got[0].q, 32'hFFFF_FFFA);
         chk("t2_r0_rem", got[0].r, 32'hFFFF_FFFE);
         chk("t2_r0_stall", got[0].stall, 1);
         chk("t2_r1_pipe", got[1].pipe, 1);
         chk("t2_r1_quot", got[1].q, 4);
         chk("t2_r1_rem", got[1].r, 1);
         chk("t2_r1_stall", got[1].stall, 0);
      end

      // Zero divisor bypass
      base = start_cnt;
      bus.req0 = 1; bus.a0 = 32'h1234; bus.b0 = 0; bus.sign0 = 0;
      #1;
      chk("t3_stall_t0", bus.stall_all, 1);
      tick();
      chk("t3_res_valid", bus.res_valid, 1);
      chk("t3_quot", bus.quot, 32'hFFFF_FFFF);
      chk("t3_rem", bus.rem, 32'h1234);
      bus.req0 = 0;
      tick();
      chk("t3_res_after", bus.res_valid, 0);
      chk("t3_no_start", start_cnt - base, 0);

      // Cancel two cycles after div_start
      lat = 5;
      bus.req0 = 1; bus.a0 = 50; bus.b0 = 5; bus.sign0 = 0;
      #1;
      tick();
      chk("t4_start", bus.div_start, 1);
      tick();
      tick();
      bus.cancel = 1; bus.req0 = 0;
      #1;
      chk("t4_stall_cancel", bus.stall_all, 1);
      tick();
      bus.cancel = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_drain_stall", bus.stall_all, 1);
         chk("t4_drain_no_res", bus.res_valid, 0);
         chk("t4_drain_no_hilo", bus.hilo_we, 0);
         tick();
      end
      chk("t4_idle_stall", bus.stall_all, 0);
      chk("t4_idle_no_res", bus.res_valid, 0);
      bus.req0 = 1; bus.a0 = 81; bus.b0 = 9; bus.sign0 = 0;
      #1;
      chk("t4_new_stall", bus.stall_all, 1);
      tick();
      chk("t4_new_start", bus.div_start, 1);
      chk("t4_new_div_a", bus.div_a, 81);
      k = 0;
      while (!bus.res_valid && k < 20) begin
         tick();
         k++;
      end
      chk("t4_new_done", bus.res_valid, 1);
      chk("t4_new_quot", bus.quot, 9);
      chk("t4_new_rem", bus.rem, 0);
      bus.req0 = 0;
      tick();

      // Cancel in DONE of pipe 0 while pipe 1 is pending
      lat = 3;
      base = start_cnt;
      bus.req0 = 1; bus.a0 = 30; bus.b0 = 4; bus.sign0 = 0;
      bus.req1 = 1; bus.a1 = 7;  bus.b1 = 7; bus.sign1 = 0;
      #1;
      repeat (5) tick();
      chk("t5_done_res", bus.res_valid, 1);
      chk("t5_done_pipe", bus.res_pipe, 0);
      bus.cancel = 1; bus.req0 = 0; bus.req1 = 0;
      #1;
      chk("t5_cancel_res", bus.res_valid, 0);
      chk("t5_cancel_hilo", bus.hilo_we, 0);
      tick();
      bus.cancel = 0;
      any_start = 0; any_res = 0; any_stall = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         any_start |= bus.div_start;
         any_res   |= bus.res_valid;
         any_stall |= bus.stall_all;
         tick();
      end
      chk("t5_no_start", any_start, 0);
      chk("t5_no_res", any_res, 0);
      chk("t5_idle", any_stall, 0);
      chk("t5_one_start", start_cnt - base, 1);

      // Reset during BUSY, then a stray completion
      mon_en = 1'b1;
      lat = 6;
      bus.req0 = 1; bus.a0 = 1000; bus.b0 = 10; bus.sign0 = 0;
      #1;
      tick();
      chk("t6_start", bus.div_start, 1);
      tick();
      rst = 1; bus.req0 = 0;
      tick();
      chk("t6_rst_start", bus.div_start, 0);
      chk("t6_rst_div_a", bus.div_a, 0);
      chk("t6_rst_div_b", bus.div_b, 0);
      chk("t6_rst_div_sign", bus.div_sign, 0);
      chk("t6_rst_stall", bus.stall_all, 0);
      chk("t6_rst_res", bus.res_valid, 0);
      chk("t6_rst_pipe", bus.res_pipe, 0);
      chk("t6_rst_quot", bus.quot, 0);
      chk("t6_rst_rem", bus.rem, 0);
      chk("t6_rst_hilo", bus.hilo_we, 0);
      rst = 0;
      any_res = 0; any_stall = 0; k = 0;
      while ((be_cnt > 0 || k < 2) && k < 20) begin
         tick();
         any_res   |= bus.res_valid;
         any_stall |= bus.stall_all;
         k++;
      end
      tick();
      any_res   |= bus.res_valid;
      any_stall |= bus.stall_all;
      chk("t6_stray_res", any_res, 0);
      chk("t6_stray_stall", any_stall, 0);
      run_bundle(1, 1000, 10, 0, 0, 0, 0, 0);
      tick();

      // Randomized bundles against the reference model
      base = start_cnt;
      exp_starts = 0;
      for (int i = 0; i < 80; i++) begin
         lat = $urandom_range(1, 6);
         sel = $urandom_range(1, 3);
         rnd_op(ra0, rb0, rs0);
         rnd_op(ra1, rb1, rs1);
         run_bundle(sel[0], ra0, rb0, rs0, sel[1], ra1, rb1, rs1);
         repeat ($urandom_range(0, 2)) tick();
      end
      repeat (5) tick();
      chk("rand_queue_empty", expq.size(), 0);
      chk("rand_start_count", start_cnt - base, exp_starts);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
